// File: rtl/sfr_bank.sv
// Bit-addressable bank of 8-bit SFRs with software/hardware write ports, registered reads and
// ACC parity. Define SFR_BANK_FWD_EN to forward same-cycle writes into read data.
module sfr_bank #(
  parameter int unsigned NUM_REGS    = 4,
  parameter logic [7:0]  BASE_ADDR   = 8'hE0,
  parameter int unsigned ADDR_STRIDE = 8,
  parameter logic [7:0]  RESET_VAL   = 8'h00,
  localparam int unsigned SelW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [7:0]      addr_i,
  input  logic [7:0]      data_in_i,
  input  logic            write_en_i,
  input  logic            write_bit_en_i,
  input  logic            bit_in_i,
  input  logic            rd_en_i,
  input  logic            rd_bit_en_i,
  input  logic            hw_wr_en_i,
  input  logic [SelW-1:0] hw_sel_i,
  input  logic [7:0]      hw_data_i,
  output logic [7:0]      rd_data_o,
  output logic            rd_bit_o,
  output logic            rd_hit_o,
  output logic            parity_o,
  output logic            hw_collision_o,
  output logic [7:0]      reg0_q_o
);

  function automatic logic [7:0] reg_addr(int unsigned idx);
    return 8'(int'(BASE_ADDR) + int'(idx * ADDR_STRIDE));
  endfunction

  logic [7:0]          reg_q [NUM_REGS];
  logic [7:0]          reg_d [NUM_REGS];
  logic [NUM_REGS-1:0] byte_hit;
  logic [NUM_REGS-1:0] bit_hit;
  logic [NUM_REGS-1:0] sw_wr;
  logic [NUM_REGS-1:0] hw_wr;
  logic [2:0]          bit_idx;

  logic [7:0] rd_data_q, rd_data_d;
  logic       rd_bit_q, rd_bit_d;
  logic       rd_hit_q, rd_hit_d;
  logic       parity_q, parity_d;
  logic       collision_q, collision_d;

  assign bit_idx = addr_i[2:0];

  // Decode and write arbitration: a software write to a register suppresses the hw write to it.
  always_comb begin
    collision_d = 1'b0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      byte_hit[i] = (addr_i == reg_addr(i));
      bit_hit[i]  = ({addr_i[7:3], 3'b000} == reg_addr(i));
      sw_wr[i]    = write_en_i && (write_bit_en_i ? bit_hit[i] : byte_hit[i]);
      hw_wr[i]    = hw_wr_en_i && (hw_sel_i == SelW'(i));
      reg_d[i]    = reg_q[i];
      if (sw_wr[i]) begin
        if (write_bit_en_i) begin
          reg_d[i][bit_idx] = bit_in_i;
        end else begin
          reg_d[i] = data_in_i;
        end
      end else if (hw_wr[i]) begin
        reg_d[i] = hw_data_i;
      end
      if (sw_wr[i] && hw_wr[i]) begin
        collision_d = 1'b1;
      end
    end
  end

  // Read path; the source is the post-write value only when forwarding is built in.
  logic [7:0] rd_byte_val;
  logic       rd_bit_val;

  always_comb begin
    rd_byte_val = 8'h00;
    rd_bit_val  = 1'b0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
`ifdef SFR_BANK_FWD_EN
      if (byte_hit[i]) rd_byte_val = rd_byte_val | reg_d[i];
      if (bit_hit[i])  rd_bit_val  = rd_bit_val | reg_d[i][bit_idx];
`else
      if (byte_hit[i]) rd_byte_val = rd_byte_val | reg_q[i];
      if (bit_hit[i])  rd_bit_val  = rd_bit_val | reg_q[i][bit_idx];
`endif
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    rd_bit_d  = rd_bit_q;
    rd_hit_d  = rd_hit_q;
    if (rd_en_i || rd_bit_en_i) begin
      rd_hit_d = (rd_en_i && |byte_hit) || (rd_bit_en_i && |bit_hit);
    end
    if (rd_en_i) begin
      rd_data_d = rd_byte_val;
    end
    if (rd_bit_en_i) begin
      rd_bit_d = rd_bit_val;
    end
  end

  // Parity tracks the next ACC value so it lines up with reg0_q without lag.
  assign parity_d = ^reg_d[0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        reg_q[i] <= RESET_VAL;
      end
      rd_data_q   <= 8'h00;
      rd_bit_q    <= 1'b0;
      rd_hit_q    <= 1'b0;
      parity_q    <= ^RESET_VAL;
      collision_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        reg_q[i] <= reg_d[i];
      end
      rd_data_q   <= rd_data_d;
      rd_bit_q    <= rd_bit_d;
      rd_hit_q    <= rd_hit_d;
      parity_q    <= parity_d;
      collision_q <= collision_d;
    end
  end

  assign rd_data_o      = rd_data_q;
  assign rd_bit_o       = rd_bit_q;
  assign rd_hit_o       = rd_hit_q;
  assign parity_o       = parity_q;
  assign hw_collision_o = collision_q;
  assign reg0_q_o       = reg_q[0];

endmodule

// File: tb/tb_sfr_bank.sv
// Directed self-checking bench for sfr_bank (default parameters).
module tb_sfr_bank;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic [7:0] addr_i = 8'h00;
  logic [7:0] data_in_i = 8'h00;
  logic       write_en_i = 1'b0;
  logic       write_bit_en_i = 1'b0;
  logic       bit_in_i = 1'b0;
  logic       rd_en_i = 1'b0;
  logic       rd_bit_en_i = 1'b0;
  logic       hw_wr_en_i = 1'b0;
  logic [1:0] hw_sel_i = 2'd0;
  logic [7:0] hw_data_i = 8'h00;
  logic [7:0] rd_data_o;
  logic       rd_bit_o;
  logic       rd_hit_o;
  logic       parity_o;
  logic       hw_collision_o;
  logic [7:0] reg0_q_o;

  int n_chk = 0;
  int n_fail = 0;

  sfr_bank dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .addr_i         (addr_i),
    .data_in_i      (data_in_i),
    .write_en_i     (write_en_i),
    .write_bit_en_i (write_bit_en_i),
    .bit_in_i       (bit_in_i),
    .rd_en_i        (rd_en_i),
    .rd_bit_en_i    (rd_bit_en_i),
    .hw_wr_en_i     (hw_wr_en_i),
    .hw_sel_i       (hw_sel_i),
    .hw_data_i      (hw_data_i),
    .rd_data_o      (rd_data_o),
    .rd_bit_o       (rd_bit_o),
    .rd_hit_o       (rd_hit_o),
    .parity_o       (parity_o),
    .hw_collision_o (hw_collision_o),
    .reg0_q_o       (reg0_q_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    write_en_i = 1'b0; write_bit_en_i = 1'b0; rd_en_i = 1'b0; rd_bit_en_i = 1'b0;
    hw_wr_en_i = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_chk++; if (reg0_q_o !== 8'h00) begin n_fail++; $display("FAIL reset_reg0 got %h want 00", reg0_q_o); end
    n_chk++; if (parity_o !== 1'b0) begin n_fail++; $display("FAIL reset_parity got %b want 0", parity_o); end
    n_chk++; if (rd_hit_o !== 1'b0) begin n_fail++; $display("FAIL reset_rd_hit got %b want 0", rd_hit_o); end
    n_chk++; if (rd_data_o !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data got %h want 00", rd_data_o); end
    n_chk++; if (hw_collision_o !== 1'b0) begin n_fail++; $display("FAIL reset_coll got %b want 0", hw_collision_o); end
    tick();
    rst_ni = 1'b1;
    tick();
    addr_i = 8'hE8; rd_en_i = 1'b1;
    tick();
    idle();
    n_chk++; if (rd_data_o !== 8'h00) begin n_fail++; $display("FAIL reset_read_e8 got %h want 00", rd_data_o); end
    n_chk++; if (rd_hit_o !== 1'b1) begin n_fail++; $display("FAIL reset_read_hit got %b want 1", rd_hit_o); end
  endtask

  task automatic test_byte_bit();
    addr_i = 8'hE0; data_in_i = 8'h5A; write_en_i = 1'b1;
    tick();
    idle();
    n_chk++; if (reg0_q_o !== 8'h5A) begin n_fail++; $display("FAIL byte_wr got %h want 5a", reg0_q_o); end
    n_chk++; if (parity_o !== 1'b0) begin n_fail++; $display("FAIL byte_par got %b want 0", parity_o); end
    addr_i = 8'hE0; bit_in_i = 1'b1; write_en_i = 1'b1; write_bit_en_i = 1'b1;
    tick();
    idle();
    n_chk++; if (reg0_q_o !== 8'h5B) begin n_fail++; $display("FAIL bit0_wr got %h want 5b", reg0_q_o); end
    n_chk++; if (parity_o !== 1'b1) begin n_fail++; $display("FAIL bit0_par got %b want 1", parity_o); end
    addr_i = 8'hE7; bit_in_i = 1'b0; write_en_i = 1'b1; write_bit_en_i = 1'b1;
    tick();
    idle();
    n_chk++; if (reg0_q_o !== 8'h5B) begin n_fail++; $display("FAIL bit7_wr got %h want 5b", reg0_q_o); end
    n_chk++; if (parity_o !== 1'b1) begin n_fail++; $display("FAIL bit7_par got %b want 1", parity_o); end
    // 0x5B bit 3 = 1, bit 2 = 0
    addr_i = 8'hE3; rd_bit_en_i = 1'b1;
    tick();
    n_chk++; if (rd_bit_o !== 1'b1) begin n_fail++; $display("FAIL bit3_rd got %b want 1", rd_bit_o); end
    n_chk++; if (rd_hit_o !== 1'b1) begin n_fail++; $display("FAIL bit3_hit got %b want 1", rd_hit_o); end
    addr_i = 8'hE2;
    tick();
    idle();
    n_chk++; if (rd_bit_o !== 1'b0) begin n_fail++; $display("FAIL bit2_rd got %b want 0", rd_bit_o); end
  endtask

  task automatic test_collision();
    addr_i = 8'hF0; data_in_i = 8'h11; write_en_i = 1'b1;
    hw_wr_en_i = 1'b1; hw_sel_i = 2'd2; hw_data_i = 8'h22;
    tick();
    idle();
    n_chk++; if (hw_collision_o !== 1'b1) begin n_fail++; $display("FAIL coll_pulse got %b want 1", hw_collision_o); end
    addr_i = 8'hF0; rd_en_i = 1'b1;
    tick();
    idle();
    n_chk++; if (hw_collision_o !== 1'b0) begin n_fail++; $display("FAIL coll_clear got %b want 0", hw_collision_o); end
    n_chk++; if (rd_data_o !== 8'h11) begin n_fail++; $display("FAIL coll_reg2 got %h want 11", rd_data_o); end
    addr_i = 8'hF0; data_in_i = 8'h11; write_en_i = 1'b1;
    hw_wr_en_i = 1'b1; hw_sel_i = 2'd1; hw_data_i = 8'h22;
    tick();
    idle();
    n_chk++; if (hw_collision_o !== 1'b0) begin n_fail++; $display("FAIL nocoll got %b want 0", hw_collision_o); end
    addr_i = 8'hE8; rd_en_i = 1'b1;
    tick();
    n_chk++; if (rd_data_o !== 8'h22) begin n_fail++; $display("FAIL hw_reg1 got %h want 22", rd_data_o); end
    addr_i = 8'hF0;
    tick();
    idle();
    n_chk++; if (rd_data_o !== 8'h11) begin n_fail++; $display("FAIL sw_reg2 got %h want 11", rd_data_o); end
  endtask

  task automatic test_unmapped();
    addr_i = 8'hE4; data_in_i = 8'hFF; write_en_i = 1'b1;
    tick();
    idle();
    n_chk++; if (reg0_q_o !== 8'h5B) begin n_fail++; $display("FAIL unmap_reg0 got %h want 5b", reg0_q_o); end
    addr_i = 8'hE4; rd_en_i = 1'b1;
    tick();
    idle();
    n_chk++; if (rd_data_o !== 8'h00) begin n_fail++; $display("FAIL unmap_rd got %h want 00", rd_data_o); end
    n_chk++; if (rd_hit_o !== 1'b0) begin n_fail++; $display("FAIL unmap_hit got %b want 0", rd_hit_o); end
    addr_i = 8'hE8; rd_en_i = 1'b1;
    tick();
    idle();
    n_chk++; if (rd_data_o !== 8'h22) begin n_fail++; $display("FAIL unmap_reg1 got %h want 22", rd_data_o); end
  endtask

  task automatic test_forward();
    logic [7:0] exp_same;
`ifdef SFR_BANK_FWD_EN
    exp_same = 8'hA5;
`else
    exp_same = 8'h00;
`endif
    addr_i = 8'hF8; data_in_i = 8'hA5; write_en_i = 1'b1; rd_en_i = 1'b1;
    tick();
    idle();
    n_chk++; if (rd_data_o !== exp_same) begin n_fail++; $display("FAIL fwd_same got %h want %h", rd_data_o, exp_same); end
    n_chk++; if (rd_hit_o !== 1'b1) begin n_fail++; $display("FAIL fwd_hit got %b want 1", rd_hit_o); end
    addr_i = 8'hF8; rd_en_i = 1'b1;
    tick();
    idle();
    n_chk++; if (rd_data_o !== 8'hA5) begin n_fail++; $display("FAIL fwd_after got %h want a5", rd_data_o); end
    addr_i = 8'hE4;
    tick();
    tick();
    n_chk++; if (rd_data_o !== 8'hA5) begin n_fail++; $display("FAIL hold_data got %h want a5", rd_data_o); end
    n_chk++; if (rd_hit_o !== 1'b1) begin n_fail++; $display("FAIL hold_hit got %b want 1", rd_hit_o); end
  endtask

  task automatic test_async_reset();
    addr_i = 8'hE0; data_in_i = 8'h77; write_en_i = 1'b1;
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    n_chk++; if (reg0_q_o !== 8'h00) begin n_fail++; $display("FAIL arst_reg0 got %h want 00", reg0_q_o); end
    n_chk++; if (parity_o !== 1'b0) begin n_fail++; $display("FAIL arst_par got %b want 0", parity_o); end
    n_chk++; if (rd_data_o !== 8'h00) begin n_fail++; $display("FAIL arst_rd got %h want 00", rd_data_o); end
    n_chk++; if (rd_hit_o !== 1'b0) begin n_fail++; $display("FAIL arst_hit got %b want 0", rd_hit_o); end
    tick();
    idle();
    rst_ni = 1'b1;
    tick();
    n_chk++; if (reg0_q_o !== 8'h00) begin n_fail++; $display("FAIL arst_after got %h want 00", reg0_q_o); end
    addr_i = 8'hF8; rd_en_i = 1'b1;
    tick();
    idle();
    n_chk++; if (rd_data_o !== 8'h00) begin n_fail++; $display("FAIL arst_reg3 got %h want 00", rd_data_o); end
  endtask

  initial begin
    test_reset();
    test_byte_bit();
    test_collision();
    test_unmapped();
    test_forward();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sfr_bank.md
Name: sfr_bank

Overview:
- Parametrised bank of bit-addressable 8-bit SFRs (ACC, B and spare slots) for the 8051 core.
- Byte writes, bit writes and reads use the direct-address bus.
- A separate hardware write port takes ALU/writeback results.
- Registered read data with one-cycle latency; registered parity of register 0 (ACC) for PSW.P.

Parameters:
- NUM_REGS, 4, number of registers, 1..16.
- BASE_ADDR, 8'hE0, byte address of register 0; must be a multiple of 8.
- ADDR_STRIDE, 8, address step between registers; must be a multiple of 8 so every register is bit-addressable.
- RESET_VAL, 8'h00, reset value of every register.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- addr  in  8  direct byte address, or bit address when a bit operation is active
- data_in  in  8  byte write data
- write_en  in  1  write strobe
- write_bit_en  in  1  qualifies write_en as a bit write
- bit_in  in  1  bit write data
- rd_en  in  1  byte read request
- rd_bit_en  in  1  bit read request (same addr decode as bit write)
- hw_wr_en  in  1  hardware write strobe
- hw_sel  in  $clog2(NUM_REGS) (min 1)  hardware target register index
- hw_data  in  8  hardware write data
- rd_data  out  8  registered read data
- rd_bit  out  1  registered bit read data
- rd_hit  out  1  previous-cycle read hit a mapped register
- parity  out  1  even parity (XOR) of register 0
- hw_collision  out  1  one-cycle pulse: hw write dropped
- reg0_q  out  8  live value of register 0 (ACC to ALU)

Behaviour:
- Address decode:
  - Register i lives at byte address A_i = BASE_ADDR + i*ADDR_STRIDE.
  - Byte hit: addr == A_i.
  - Bit hit: {addr[7:3],3'b000} == A_i; bit index = addr[2:0].
  - Addresses outside the bank are ignored for writes and miss for reads.
- Reset (reset=0, asynchronous):
  - All registers = RESET_VAL.
  - rd_data = 0, rd_bit = 0, rd_hit = 0, hw_collision = 0.
  - parity = ^RESET_VAL.
- Writes (all take effect at the clock edge; register updated next cycle):
  - Byte write: write_en=1, write_bit_en=0, byte hit → reg = data_in.
  - Bit write: write_en=1, write_bit_en=1, bit hit → only reg[addr[2:0]] = bit_in; other bits unchanged.
  - Hardware write: hw_wr_en=1, hw_sel < NUM_REGS → reg[hw_sel] = hw_data. hw_sel >= NUM_REGS is ignored, with no collision pulse.
- Same-cycle conflict:
  - If a software write (byte or bit) and a hw write hit the same register, the software write wins and the hw write is dropped entirely.
  - hw_collision = 1 for exactly the following cycle.
  - If they target different registers, both writes complete.
- Reads:
  - rd_en sampled at edge N → rd_data and rd_hit valid after edge N (one-cycle latency).
  - Hit: rd_data = register value before any write at edge N, unless forwarding is enabled (see Optional Feature).
  - Miss: rd_data = 0, rd_hit = 0.
  - rd_bit_en works the same way: rd_bit = selected bit, rd_hit = bit hit.
  - rd_en and rd_bit_en together: both outputs update; rd_hit = byte hit OR bit hit.
  - With neither request active, rd_data, rd_bit and rd_hit hold their previous values.
- parity:
  - Registered.
  - Equals the XOR of register 0's value after the same edge, so it always matches reg0_q with no extra lag.
- reg0_q: direct register output, no added latency.
- Reset mid-operation: any pending write is lost; outputs go to reset values immediately.

Optional Feature:
- Macro SFR_BANK_FWD_EN.
- Defined:
  - A read sampled in the same cycle as a write to the same register returns the post-write value.
  - Bit reads see the written bit.
  - The software-over-hw priority also applies to the forwarded value.
- Undefined: same-cycle reads return the pre-write value.

Test Plan:
- Reset check: hold reset=0 → all registers 8'h00, parity=0, rd_hit=0. Then release reset, rd_en at 8'hE8 → rd_data=8'h00 and rd_hit=1 one cycle later.
- Byte/bit write and parity:
  - Write 8'h5A to 8'hE0 → reg0_q=8'h5A, parity=0.
  - Bit write bit_in=1 at addr 8'hE0 (bit 0) → reg0_q=8'h5B, parity=1.
  - Bit write bit_in=0 at 8'hE7 → reg0_q=8'h5B (bit 7 already 0), parity=1.
- Collision: same cycle, byte write 8'h11 to 8'hF0 and hw write hw_sel=2, hw_data=8'h22 → reg2=8'h11, hw_collision=1 for one cycle. Same again with hw_sel=1 → reg1=8'h22, reg2=8'h11, no collision.
- Unmapped access: write 8'hFF to 8'hE4 (not a byte hit), then rd_en at 8'hE4 → no register changes, rd_data=8'h00, rd_hit=0.
- Forwarding: reg3=8'h00, then same cycle write 8'hA5 to 8'hF8 and rd_en at 8'hF8 → rd_data=8'hA5 with SFR_BANK_FWD_EN, 8'h00 without it.
- Async reset mid-write: assert reset between edges while write_en is pending → registers = RESET_VAL immediately, no write after release.
